turtle_clock_reset_ctrl: RTL and testbench
==========================================

# turtle_clock_reset_ctrl

Front-panel clock and reset controller that sits directly upstream of the turtle CPU subsystem. It synchronizes and debounces the raw board inputs `reset_btn`, `manual_clk_sw` and `pulse_clk_btn`. It produces the core's clock-enable (`cpu_clk_en`) and its stretched, synchronous-release active-low reset (`cpu_reset_n`). It supports free-running (auto) mode and single-step (manual) mode, and keeps a count of executed CPU cycles for display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000. Consecutive stable `clk` cycles required to accept an input change. Minimum 1.
- `RESET_HOLD_CYCLES`, default 16. Cycles `cpu_reset_n` stays low after all reset sources release. Minimum 1.
- `AUTO_DIV`, default 1. In auto mode, `cpu_clk_en` fires once every `AUTO_DIV` cycles. 1 means every cycle.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high system reset.
- `reset_btn`  input  1  raw, asynchronous, active-high reset button.
- `manual_clk_sw`  input  1  raw mode switch. 1 selects manual mode.
- `pulse_clk_btn`  input  1  raw single-step button.
- `cpu_clk_en`  output  1  one-cycle CPU advance strobe.
- `cpu_reset_n`  output  1  active-low CPU reset.
- `manual_mode`  output  1  debounced `manual_clk_sw`.
- `cpu_cycle_count`  output  16  number of `cpu_clk_en` pulses since the last CPU reset.

## Operation
- Reset values (`reset`=1): all outputs 0. That is `cpu_clk_en`=0, `cpu_reset_n`=0, `manual_mode`=0, `cpu_cycle_count`=0. All debounced states are 0, all counters are 0, and the FSM is in `RST_HOLD`.
- Input conditioning, applied per raw input:
  - 2-flop synchronizer.
  - Debounce counter: increments while the synchronized value differs from the stable value, and clears when they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable value takes the synchronized value and the counter clears.
- Reset FSM:
  - `RST_HOLD`: `cpu_reset_n`=0. A hold counter counts only while `reset` and the debounced `reset_btn` are both 0. When the count reaches `RESET_HOLD_CYCLES`, go to `RST_RUN`.
  - `RST_RUN`: `cpu_reset_n`=1. If the debounced `reset_btn` is 1, go to `RST_HOLD` and clear the hold counter.
  - `reset` forces `RST_HOLD` asynchronously.
- `cpu_clk_en` is forced to 0 whenever `cpu_reset_n`=0.
- Auto mode (`manual_mode`=0):
  - A divider counts 0 to `AUTO_DIV`-1 and wraps.
  - `cpu_clk_en`=1 on the cycle the divider equals `AUTO_DIV`-1.
  - The divider is held at 0 while in `RST_HOLD`.
- Manual mode (`manual_mode`=1): each rising edge of the debounced `pulse_clk_btn` produces exactly one `cpu_clk_en` cycle. Holding the button produces no further pulses.
- Mode change:
  - The divider clears on any change of `manual_mode`.
  - The edge detector's previous-value flop tracks the debounced button continuously. Consequences:
    - A button that is already held when switching into manual mode produces no pulse.
    - Presses made in auto mode are discarded, never queued.
- `cpu_cycle_count` increments on every `cpu_clk_en` cycle, wraps 0xFFFF to 0x0000, and clears while `cpu_reset_n`=0.

## Timing
- All outputs are registered.
- Raw input step held stable: the debounced value changes at `clk` edge 2+`DEBOUNCE_CYCLES` after the first edge that samples the new raw value.
- Manual step: `cpu_clk_en` is high for exactly one cycle, rising `DEBOUNCE_CYCLES`+3 edges after the raw `pulse_clk_btn` rises.
- Reset button: `cpu_reset_n` falls 1 edge after the debounced `reset_btn` rises.
- Reset release: `cpu_reset_n` rises `RESET_HOLD_CYCLES` edges after both the debounced `reset_btn` and `reset` are 0.
- Auto mode after reset release: the first `cpu_clk_en` occurs `AUTO_DIV` edges after `cpu_reset_n` rises. Pulses then repeat with period `AUTO_DIV`.
- Simultaneous events:
  - A step press in the same cycle that reset asserts is dropped.
  - A `reset_btn` assertion in the middle of a manual step suppresses `cpu_clk_en` immediately.
  - A reset-button glitch shorter than `DEBOUNCE_CYCLES` has no effect.

## Structure
- Shared package `turtle_cpu_pkg` gains `typedef enum logic {RST_HOLD, RST_RUN} rst_state_t`.
- Sub-module `button_debouncer` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `raw_in`, `stable_out`) is instantiated three times.
- The top-level level holds the reset FSM, divider, edge detector and cycle counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `RESET_HOLD_CYCLES`=3, `AUTO_DIV`=2.
- Power-on: `reset` is held high for 5 cycles, then released. Required: `cpu_reset_n` stays 0 until 3 edges after release. `cpu_clk_en` then toggles 0,1,0,1 and `cpu_cycle_count` reaches 4 after 8 cycles.
- Manual step: switch to manual mode, then hold `pulse_clk_btn` for 20 cycles. Required: exactly one `cpu_clk_en`, appearing 7 edges after the press, and `cpu_cycle_count` increments by 1.
- Bounce rejection: `pulse_clk_btn` toggles every 2 cycles for 16 cycles, then settles at 1. Required: exactly one `cpu_clk_en`, appearing 7 edges after settling.
- Reset button mid-run: in auto mode, pulse `reset_btn` for 10 cycles. Required: `cpu_reset_n` is 0 from the debounced rise until 3 edges after the debounced fall, no `cpu_clk_en` in that window, and the count is 0 afterwards.
- Mode switch with button held: hold `pulse_clk_btn` in auto mode, then switch to manual. Required: no `cpu_clk_en` until the button is released and pressed again.
- Wrap: preload `cpu_cycle_count` to 0xFFFE via force, then run 2 enables. Required: the count reads 0x0000.

Source files
------------

// File: rtl/turtle_cpu_pkg.sv
// Shared types and helpers for the turtle CPU subsystem.
// Holds the front-panel reset FSM state type and counter sizing helpers.
package turtle_cpu_pkg;

  typedef enum logic {RST_HOLD, RST_RUN} rst_state_t;

  localparam int CYCLE_CNT_W = 16;

  // Width of a counter that must hold values 0..max_val, never narrower than 1 bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/turtle_clock_reset_ctrl_if.sv
// Front-panel bundle between the board inputs, the clock/reset controller and the CPU core.
interface turtle_clock_reset_ctrl_if;
  import turtle_cpu_pkg::*;

  logic                   reset_btn;
  logic                   manual_clk_sw;
  logic                   pulse_clk_btn;
  // cpu_clk_en is a single-cycle strobe with no back-pressure: the core advances on every
  // cycle it is high and must accept it; it is never high while cpu_reset_n is low.
  logic                   cpu_clk_en;
  logic                   cpu_reset_n;
  logic                   manual_mode;
  logic [CYCLE_CNT_W-1:0] cpu_cycle_count;
  rst_state_t             rst_state;

  modport master (
    input  reset_btn, manual_clk_sw, pulse_clk_btn,
    output cpu_clk_en, cpu_reset_n, manual_mode, cpu_cycle_count, rst_state
  );

  modport slave (
    output reset_btn, manual_clk_sw, pulse_clk_btn,
    input  cpu_clk_en, cpu_reset_n, manual_mode, cpu_cycle_count, rst_state
  );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stability counter for one raw board input.
// The stable value only follows the synchronized input after DEBOUNCE_CYCLES unchanged cycles.
module button_debouncer
  import turtle_cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic stable_out
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter restarts from zero whenever the input agrees with the accepted value.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_out = stable_q;

endmodule

// File: rtl/turtle_clock_reset_ctrl.sv
// Front-panel clock/reset controller: stretched CPU reset, auto/single-step clock enable
// and an executed-cycle counter, all driven from debounced board inputs.
module turtle_clock_reset_ctrl
  import turtle_cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int AUTO_DIV          = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  turtle_clock_reset_ctrl_if.master bus
);

  localparam int            HW        = cnt_width(RESET_HOLD_CYCLES);
  localparam int            DW        = cnt_width(AUTO_DIV);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(AUTO_DIV - 1);

  logic btn_db, mode_db, step_db;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_btn_db (
    .clk(clk), .reset(reset), .raw_in(bus.reset_btn), .stable_out(btn_db)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_sw_db (
    .clk(clk), .reset(reset), .raw_in(bus.manual_clk_sw), .stable_out(mode_db)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pulse_btn_db (
    .clk(clk), .reset(reset), .raw_in(bus.pulse_clk_btn), .stable_out(step_db)
  );

  rst_state_t             state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [DW-1:0]          div_q, div_d;
  logic                   step_prev_q;
  logic                   clk_en_q, clk_en_d;
  logic                   rst_n_q, rst_n_d;
  logic [CYCLE_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic                   step_rise, auto_fire, stay_run;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      RST_HOLD: begin
        if (btn_db) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RST_RUN: begin
        if (btn_db) begin
          state_d = RST_HOLD;
          hold_d  = '0;
        end
      end
    endcase

    rst_n_d   = (state_d == RST_RUN);
    stay_run  = (state_q == RST_RUN) && rst_n_d;
    step_rise = step_db && !step_prev_q;
    auto_fire = (div_q == DIV_LAST);

    // Enable is gated by the next reset state so a reset press kills a pending step at once.
    clk_en_d = stay_run && (mode_db ? step_rise : auto_fire);

    // Parked at zero in manual mode, so every mode change restarts the divider from zero.
    if (!stay_run || mode_db || auto_fire) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (!rst_n_d) begin
      cycle_cnt_d = '0;
    end else begin
      cycle_cnt_d = cycle_cnt_q + {{(CYCLE_CNT_W-1){1'b0}}, clk_en_d};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_HOLD;
      hold_q      <= '0;
      div_q       <= '0;
      step_prev_q <= 1'b0;
      clk_en_q    <= 1'b0;
      rst_n_q     <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      div_q       <= div_d;
      step_prev_q <= step_db;
      clk_en_q    <= clk_en_d;
      rst_n_q     <= rst_n_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.cpu_clk_en      = clk_en_q;
  assign bus.cpu_reset_n     = rst_n_q;
  assign bus.manual_mode     = mode_db;
  assign bus.cpu_cycle_count = cycle_cnt_q;
  assign bus.rst_state       = state_q;

endmodule

// File: tb/tb_turtle_clock_reset_ctrl.sv
// Directed bench for the front-panel clock/reset controller with
// DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=3, AUTO_DIV=2.
module tb_turtle_clock_reset_ctrl;
  import turtle_cpu_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  turtle_clock_reset_ctrl_if bus ();

  turtle_clock_reset_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD_CYCLES(3),
    .AUTO_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled and inputs driven 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Press the step button for 'hold' edges, release and watch 10 more edges.
  task automatic do_press(input int hold, output int n_en, output int first_at);
    n_en     = 0;
    first_at = -1;
    bus.pulse_clk_btn = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      step();
      if (bus.cpu_clk_en === 1'b1) begin
        n_en++;
        if (first_at < 0) first_at = k;
      end
    end
    bus.pulse_clk_btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.cpu_clk_en === 1'b1) n_en++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.reset_btn = 1'b0;
    bus.manual_clk_sw = 1'b0;
    bus.pulse_clk_btn = 1'b0;
    wait_cycles(5);
    tests_run++;
    if (bus.cpu_clk_en !== 1'b0) begin
      tests_failed++; $display("FAIL reset_clk_en: got %b expected 0", bus.cpu_clk_en);
    end
    tests_run++;
    if (bus.cpu_reset_n !== 1'b0) begin
      tests_failed++; $display("FAIL reset_reset_n: got %b expected 0", bus.cpu_reset_n);
    end
    tests_run++;
    if (bus.manual_mode !== 1'b0) begin
      tests_failed++; $display("FAIL reset_manual_mode: got %b expected 0", bus.manual_mode);
    end
    tests_run++;
    if (bus.cpu_cycle_count !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_count: got %h expected 0000", bus.cpu_cycle_count);
    end
    tests_run++;
    if (bus.rst_state !== RST_HOLD) begin
      tests_failed++; $display("FAIL reset_state: got %0d expected %0d", bus.rst_state, RST_HOLD);
    end

    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests_run++;
      if (bus.cpu_reset_n !== (k == 3)) begin
        tests_failed++;
        $display("FAIL release_reset_n edge %0d: got %b expected %b", k, bus.cpu_reset_n, (k == 3));
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      tests_run++;
      if (bus.cpu_clk_en !== ((k % 2) == 0)) begin
        tests_failed++;
        $display("FAIL auto_clk_en edge %0d: got %b expected %b", k, bus.cpu_clk_en, ((k % 2) == 0));
      end
    end
    tests_run++;
    if (bus.cpu_cycle_count !== 16'd4) begin
      tests_failed++; $display("FAIL auto_count: got %0d expected 4", bus.cpu_cycle_count);
    end
  endtask

  task automatic test_manual_step();
    logic [15:0] base;
    int n_en, first_at;
    bus.manual_clk_sw = 1'b1;
    wait_cycles(5);
    tests_run++;
    if (bus.manual_mode !== 1'b0) begin
      tests_failed++; $display("FAIL mode_early: got %b expected 0", bus.manual_mode);
    end
    step();
    tests_run++;
    if (bus.manual_mode !== 1'b1) begin
      tests_failed++; $display("FAIL mode_settle: got %b expected 1", bus.manual_mode);
    end
    wait_cycles(2);
    base = bus.cpu_cycle_count;
    do_press(20, n_en, first_at);
    tests_run++;
    if (n_en !== 1) begin
      tests_failed++; $display("FAIL step_pulses: got %0d expected 1", n_en);
    end
    tests_run++;
    if (first_at !== 7) begin
      tests_failed++; $display("FAIL step_latency: got %0d expected 7", first_at);
    end
    tests_run++;
    if (bus.cpu_cycle_count !== base + 16'd1) begin
      tests_failed++; $display("FAIL step_count: got %0d expected %0d", bus.cpu_cycle_count, base + 16'd1);
    end
  endtask

  task automatic test_bounce();
    int n_bounce, n_en, first_at;
    n_bounce = 0;
    for (int i = 0; i < 16; i++) begin
      bus.pulse_clk_btn = (((i / 2) % 2) == 0);
      step();
      if (bus.cpu_clk_en === 1'b1) n_bounce++;
    end
    tests_run++;
    if (n_bounce !== 0) begin
      tests_failed++; $display("FAIL bounce_pulses: got %0d expected 0", n_bounce);
    end
    do_press(20, n_en, first_at);
    tests_run++;
    if (n_en !== 1) begin
      tests_failed++; $display("FAIL settle_pulses: got %0d expected 1", n_en);
    end
    tests_run++;
    if (first_at !== 7) begin
      tests_failed++; $display("FAIL settle_latency: got %0d expected 7", first_at);
    end
  endtask

  task automatic test_mode_switch_held();
    int n_en, first_at;
    bus.manual_clk_sw = 1'b0;
    wait_cycles(8);
    bus.pulse_clk_btn = 1'b1;
    wait_cycles(8);
    bus.manual_clk_sw = 1'b1;
    wait_cycles(6);
    tests_run++;
    if (bus.manual_mode !== 1'b1) begin
      tests_failed++; $display("FAIL held_mode: got %b expected 1", bus.manual_mode);
    end
    n_en = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.cpu_clk_en === 1'b1) n_en++;
    end
    tests_run++;
    if (n_en !== 0) begin
      tests_failed++; $display("FAIL held_pulses: got %0d expected 0", n_en);
    end
    bus.pulse_clk_btn = 1'b0;
    wait_cycles(8);
    do_press(12, n_en, first_at);
    tests_run++;
    if (n_en !== 1 || first_at !== 7) begin
      tests_failed++;
      $display("FAIL repress: got %0d pulses at %0d expected 1 at 7", n_en, first_at);
    end
  endtask

  task automatic test_reset_btn();
    logic exp_rst_n;
    bus.manual_clk_sw = 1'b0;
    wait_cycles(8);
    tests_run++;
    if (bus.manual_mode !== 1'b0) begin
      tests_failed++; $display("FAIL auto_mode: got %b expected 0", bus.manual_mode);
    end
    bus.reset_btn = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      if (k == 11) bus.reset_btn = 1'b0;
      step();
      exp_rst_n = (k < 7) || (k >= 19);
      tests_run++;
      if (bus.cpu_reset_n !== exp_rst_n) begin
        tests_failed++;
        $display("FAIL btn_reset_n edge %0d: got %b expected %b", k, bus.cpu_reset_n, exp_rst_n);
      end
      if (!exp_rst_n) begin
        tests_run++;
        if (bus.cpu_clk_en !== 1'b0 || bus.cpu_cycle_count !== 16'd0) begin
          tests_failed++;
          $display("FAIL btn_window edge %0d: got en=%b cnt=%0d expected en=0 cnt=0",
                   k, bus.cpu_clk_en, bus.cpu_cycle_count);
        end
        tests_run++;
        if (bus.rst_state !== RST_HOLD) begin
          tests_failed++; $display("FAIL btn_state edge %0d: got %0d expected %0d", k, bus.rst_state, RST_HOLD);
        end
      end
      if (k == 20 || k == 21) begin
        tests_run++;
        if (bus.cpu_clk_en !== (k == 21) || bus.cpu_cycle_count !== ((k == 21) ? 16'd1 : 16'd0)) begin
          tests_failed++;
          $display("FAIL btn_restart edge %0d: got en=%b cnt=%0d expected en=%b cnt=%0d",
                   k, bus.cpu_clk_en, bus.cpu_cycle_count, (k == 21), (k == 21));
        end
      end
    end
  endtask

  task automatic test_reset_glitch();
    int n_low;
    n_low = 0;
    bus.reset_btn = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) bus.reset_btn = 1'b0;
      step();
      if (bus.cpu_reset_n !== 1'b1) n_low++;
    end
    tests_run++;
    if (n_low !== 0) begin
      tests_failed++; $display("FAIL glitch_reset_n: got %0d low cycles expected 0", n_low);
    end
  endtask

  task automatic test_wrap();
    int n_en, first_at;
    bus.manual_clk_sw = 1'b1;
    wait_cycles(8);
    @(negedge clk);
    force dut.cycle_cnt_q = 16'hFFFE;
    wait_cycles(2);
    @(negedge clk);
    release dut.cycle_cnt_q;
    step();
    tests_run++;
    if (bus.cpu_cycle_count !== 16'hFFFE) begin
      tests_failed++; $display("FAIL wrap_preload: got %h expected fffe", bus.cpu_cycle_count);
    end
    do_press(12, n_en, first_at);
    tests_run++;
    if (n_en !== 1 || bus.cpu_cycle_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_first: got %0d pulses cnt=%h expected 1 pulse cnt=ffff", n_en, bus.cpu_cycle_count);
    end
    do_press(12, n_en, first_at);
    tests_run++;
    if (n_en !== 1 || bus.cpu_cycle_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_second: got %0d pulses cnt=%h expected 1 pulse cnt=0000", n_en, bus.cpu_cycle_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    bus.reset_btn = 1'b0;
    bus.manual_clk_sw = 1'b0;
    bus.pulse_clk_btn = 1'b0;
    test_reset();
    test_manual_step();
    test_bounce();
    test_mode_switch_held();
    test_reset_btn();
    test_reset_glitch();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
